// File: rtl/ht_reset_sequencer.sv
// Staged reset-release controller: holds all domains in reset for a minimum width,
// then releases them one at a time in index order, gated by the previous domain's ready.
module ht_reset_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int MIN_ASSERT    = 16,
    parameter int STAGE_GAP     = 8,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic [NUM_STAGES-1:0] i_stage_ready,
    output logic [NUM_STAGES-1:0] o_reset,
    output logic                  o_all_released,
    output logic                  o_timeout
);

    localparam int MAX_AG  = (MIN_ASSERT > STAGE_GAP) ? MIN_ASSERT : STAGE_GAP;
    localparam int MAX_CNT = (MAX_AG > READY_TIMEOUT) ? MAX_AG : READY_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] ASSERT_END = CNT_W'(MIN_ASSERT);
    localparam logic [CNT_W-1:0] GAP_END    = CNT_W'(STAGE_GAP);
    localparam logic [CNT_W-1:0] TO_END     = CNT_W'(READY_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'((NUM_STAGES > 1) ? NUM_STAGES - 2 : 0);

    typedef enum logic [2:0] {
        S_HOLD,
        S_ASSERT,
        S_GAP,
        S_WAIT_RDY,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_STAGES-1:0]   reset_q, reset_d;
    logic                    all_rel_q, all_rel_d;
    logic                    timeout_q, timeout_d;
    logic                    stage_release;
    logic                    ready_sel;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    assign ready_sel = i_stage_ready[idx_q];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        reset_d       = reset_q;
        all_rel_d     = all_rel_q;
        timeout_d     = timeout_q;
        stage_release = 1'b0;

        case (state_q)
            S_HOLD: begin
                // The first edge with reset low is already cycle 1 of the hold width.
                state_d = S_ASSERT;
                cnt_d   = CNT_ONE;
            end
            S_ASSERT: begin
                if (cnt_q == ASSERT_END) begin
                    reset_d = reset_q << 1;
                    if (NUM_STAGES == 1) begin
                        state_d   = S_DONE;
                        all_rel_d = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        cnt_d   = CNT_ONE;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_END) begin
                    if (ready_sel) begin
                        stage_release = 1'b1;
                    end else begin
                        state_d = S_WAIT_RDY;
                        cnt_d   = CNT_ONE;
                    end
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            S_WAIT_RDY: begin
                if (ready_sel) begin
                    stage_release = 1'b1;
                end else if ((READY_TIMEOUT != 0) && (cnt_q == TO_END)) begin
                    stage_release = 1'b1;
                    timeout_d     = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d = S_DONE;
            end
        endcase

        // Releases shift a zero in from the bottom, keeping the reset vector a thermometer.
        if (stage_release) begin
            reset_d = reset_q << 1;
            cnt_d   = CNT_ONE;
            if (idx_q == LAST_IDX) begin
                state_d   = S_DONE;
                all_rel_d = 1'b1;
            end else begin
                state_d = S_GAP;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            reset_q   <= '1;
            all_rel_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            reset_q   <= reset_d;
            all_rel_q <= all_rel_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_reset        = reset_q;
    assign o_all_released = all_rel_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_ht_reset_sequencer.sv
// Bench for ht_reset_sequencer: two configurations driven side by side, checked every cycle
// against an event-time model, plus literal release edges for the directed scenarios.
module tb_ht_reset_sequencer;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          i_reset;
    logic [NS-1:0] ready_a, ready_b;
    logic [NS-1:0] rst_a, rst_b;
    logic          all_a, all_b, to_a, to_b;

    always #5 clk = ~clk;

    ht_reset_sequencer #(.NUM_STAGES(NS), .MIN_ASSERT(16), .STAGE_GAP(8), .READY_TIMEOUT(32)) u_dut_a (
        .clk(clk), .i_reset(i_reset), .i_stage_ready(ready_a),
        .o_reset(rst_a), .o_all_released(all_a), .o_timeout(to_a)
    );

    ht_reset_sequencer #(.NUM_STAGES(NS), .MIN_ASSERT(16), .STAGE_GAP(1), .READY_TIMEOUT(0)) u_dut_b (
        .clk(clk), .i_reset(i_reset), .i_stage_ready(ready_b),
        .o_reset(rst_b), .o_all_released(all_b), .o_timeout(to_b)
    );

    int P_MA [2] = '{16, 16};
    int P_G  [2] = '{8, 1};
    int P_T  [2] = '{32, 0};

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;
    int t0abs = 0;

    // Model: number of released stages, time of the last release, sticky timeout.
    bit m_valid   [2];
    bit m_started [2];
    bit m_to      [2];
    int m_rel     [2];
    int m_t0      [2];
    int m_fall    [2];

    // Observed DUT events (absolute edge numbers).
    logic [NS-1:0] prev_a, prev_b;
    logic          prev_to_a;
    int fall_a [NS];
    int fall_b [NS];
    int to_rise_a;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    function automatic void model_step(input int i, input logic [NS-1:0] rdy);
        if (i_reset) begin
            m_valid[i]   = 1'b1;
            m_started[i] = 1'b0;
            m_rel[i]     = 0;
            m_to[i]      = 1'b0;
        end else if (m_valid[i]) begin
            if (!m_started[i]) begin
                m_started[i] = 1'b1;
                m_t0[i]      = ecnt;
            end else if (m_rel[i] == 0) begin
                if (ecnt == m_t0[i] + P_MA[i]) begin
                    m_rel[i]  = 1;
                    m_fall[i] = ecnt;
                end
            end else if (m_rel[i] < NS) begin
                if (ecnt >= m_fall[i] + P_G[i]) begin
                    if (rdy[m_rel[i]-1]) begin
                        m_rel[i]  = m_rel[i] + 1;
                        m_fall[i] = ecnt;
                    end else if (P_T[i] != 0 && ecnt == m_fall[i] + P_G[i] + P_T[i]) begin
                        m_rel[i]  = m_rel[i] + 1;
                        m_fall[i] = ecnt;
                        m_to[i]   = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic cycle_check();
        logic [NS-1:0] ea, eb;
        if (m_valid[0]) begin
            ea = 4'hF << m_rel[0];
            eb = 4'hF << m_rel[1];
            chk("o_reset_a", int'(rst_a), int'(ea));
            chk("all_rel_a", int'(all_a), int'(m_rel[0] == NS));
            chk("timeout_a", int'(to_a), int'(m_to[0]));
            chk("o_reset_b", int'(rst_b), int'(eb));
            chk("all_rel_b", int'(all_b), int'(m_rel[1] == NS));
            chk("timeout_b", int'(to_b), int'(m_to[1]));
            for (int k = 0; k < NS; k++) begin
                if (prev_a[k] === 1'b1 && rst_a[k] === 1'b0) fall_a[k] = ecnt;
                if (prev_b[k] === 1'b1 && rst_b[k] === 1'b0) fall_b[k] = ecnt;
            end
            if (prev_to_a === 1'b0 && to_a === 1'b1) to_rise_a = ecnt;
        end
        prev_a    = rst_a;
        prev_b    = rst_b;
        prev_to_a = to_a;
    endtask

    task automatic tick(input logic rst, input logic [NS-1:0] ra, input logic [NS-1:0] rb);
        i_reset = rst;
        ready_a = ra;
        ready_b = rb;
        @(posedge clk);
        ecnt++;
        model_step(0, ra);
        model_step(1, rb);
        @(negedge clk);
        cycle_check();
    endtask

    task automatic run_sc(input int sc, input int len);
        logic          rst;
        logic [NS-1:0] ra, rb;
        for (int r = 0; r < 3; r++) tick(1'b1, 4'h0, 4'h0);
        for (int c = 0; c < len; c++) begin
            rst = 1'b0;
            ra  = 4'hF;
            rb  = 4'hF;
            case (sc)
                1: begin
                    ra[1] = (c >= 50);
                    rb[2] = (c >= 200);
                end
                2: ra[0] = 1'b0;
                3: rst = (c == 28);
                4: ra[0] = (c >= 17 && c <= 23);
                5: begin
                    rst = ($urandom_range(0, 199) == 0);
                    for (int k = 0; k < NS; k++) begin
                        ra[k] = ($urandom_range(0, 3) == 0);
                        rb[k] = ($urandom_range(0, 3) == 0);
                    end
                end
                default: ;
            endcase
            tick(rst, ra, rb);
            if (c == 0) t0abs = ecnt;
            if (sc == 3 && c == 28) begin
                chk("pulse_rst_a", int'(rst_a), 15);
                chk("pulse_rst_b", int'(rst_b), 15);
                chk("pulse_to_a", int'(to_a), 0);
            end
            if (sc == 1 && c == 199) begin
                chk("b_stage3_held", int'(rst_b[3]), 1);
                chk("b_allrel_low", int'(all_b), 0);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1;
        ready_a = '0;
        ready_b = '0;
        for (int k = 0; k < NS; k++) begin
            fall_a[k] = -1;
            fall_b[k] = -1;
        end
        to_rise_a = -1;

        tick(1'b1, 4'h0, 4'h0);
        chk("reset_orst_a", int'(rst_a), 15);
        chk("reset_all_a", int'(all_a), 0);
        chk("reset_to_a", int'(to_a), 0);

        run_sc(0, 60);
        chk("s0_a_fall0", fall_a[0] - t0abs, 16);
        chk("s0_a_fall1", fall_a[1] - t0abs, 24);
        chk("s0_a_fall2", fall_a[2] - t0abs, 32);
        chk("s0_a_fall3", fall_a[3] - t0abs, 40);
        chk("s0_a_allrel", int'(all_a), 1);
        chk("s0_a_timeout", int'(to_a), 0);
        chk("s0_b_fall0", fall_b[0] - t0abs, 16);
        chk("s0_b_fall1", fall_b[1] - t0abs, 17);
        chk("s0_b_fall2", fall_b[2] - t0abs, 18);
        chk("s0_b_fall3", fall_b[3] - t0abs, 19);

        run_sc(1, 210);
        chk("s1_a_fall2", fall_a[2] - t0abs, 50);
        chk("s1_a_fall3", fall_a[3] - t0abs, 58);
        chk("s1_a_timeout", int'(to_a), 0);
        chk("s1_b_fall3", fall_b[3] - t0abs, 200);
        chk("s1_b_timeout", int'(to_b), 0);

        run_sc(2, 80);
        chk("s2_a_fall1", fall_a[1] - t0abs, 56);
        chk("s2_a_fall2", fall_a[2] - t0abs, 64);
        chk("s2_a_fall3", fall_a[3] - t0abs, 72);
        chk("s2_a_to_rise", to_rise_a - t0abs, 56);
        chk("s2_model_to", int'(m_to[0]), 1);

        run_sc(3, 80);
        chk("s3_a_fall0", fall_a[0] - t0abs, 45);
        chk("s3_a_fall3", fall_a[3] - t0abs, 69);
        chk("s3_b_fall3", fall_b[3] - t0abs, 48);
        chk("s3_a_timeout", int'(to_a), 0);

        run_sc(4, 80);
        chk("s4_a_fall1", fall_a[1] - t0abs, 56);
        chk("s4_a_timeout", int'(to_a), 1);

        run_sc(5, 3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
